// File: rtl/memory_access_ctrl_pkg.sv
// Shared definitions for the memory access controller slice.
//   ADDR_W / DATA_W / NUM_BYTES : geometry of the 4-byte memory array
//   mac_state_t                 : controller FSM states
package mem_pkg;

    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 8;
    localparam int NUM_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WR_HOLD,
        S_VERIFY,
        S_SETTLE,
        S_CAPTURE,
        S_DWELL
    } mac_state_t;

endpackage

// File: rtl/memory_access_ctrl_if.sv
// Bus bundle between the write requester / memory array / display path and
// the memory access controller.
//   wr_req, wr_addr, wr_data, wr_ack : write request handshake
//   scan_en                          : readback scan enable
//   mem_addr, mem_data, mem_store    : memory array write/address port
//   mem_rdata                        : combinational memory read data
//   disp_byte, disp_addr, disp_valid : latched display byte
//   wr_err                           : readback mismatch flag
// Modports: slave = controller view, master = requester/memory/display view.
interface memory_access_ctrl_if;
    import mem_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              scan_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_store;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] disp_byte;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic              wr_err;

    modport slave (
        input  wr_req, wr_addr, wr_data, scan_en, mem_rdata,
        output wr_ack, mem_addr, mem_data, mem_store,
               disp_byte, disp_addr, disp_valid, wr_err
    );

    modport master (
        output wr_req, wr_addr, wr_data, scan_en, mem_rdata,
        input  wr_ack, mem_addr, mem_data, mem_store,
               disp_byte, disp_addr, disp_valid, wr_err
    );

endinterface

// File: rtl/memory_access_ctrl_dwell.sv
// Dwell timer: loadable down-counter that holds at zero.
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : load load_val_i (wins over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one (no effect at zero)
//   done_o      : counter is zero
module dwell_timer #(
    parameter int DWELL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               done_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - DWELL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/memory_access_ctrl.sv
// Initiator-side controller for the 4-byte memory array. Issues single-cycle
// store strobes for requested writes and, between writes, scans bytes 0..3,
// holding each on the display outputs for DWELL cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : memory_access_ctrl_if.slave (write handshake, memory port,
//                display outputs, wr_err)
// Parameters: DWELL (cycles per displayed byte, >= 1), DWELL_W (counter width).
// Optional macro MEMORY_ACCESS_CTRL_VERIFY_EN: adds a VERIFY cycle after each
// write that reads the byte back and drives wr_err; otherwise wr_err is 0.
module memory_access_ctrl
    import mem_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int DWELL_W = $clog2(DWELL + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    memory_access_ctrl_if.slave  bus
);

    mac_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] disp_byte_q, disp_byte_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic              disp_valid_q, disp_valid_d;
    logic              tmr_load, tmr_dec, tmr_done;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
    logic              wr_err_q, wr_err_d;
`endif

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (DWELL_W'(DWELL - 1)),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        scan_ptr_d   = scan_ptr_q;
        disp_byte_d  = disp_byte_q;
        disp_addr_d  = disp_addr_q;
        disp_valid_d = disp_valid_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        // mem_addr is driven combinationally from the state so it is valid in
        // the same cycle; mem_addr_q only remembers it for the idle/dwell hold.
        mem_addr_d   = mem_addr_q;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
        wr_err_d     = wr_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.wr_req) begin
                    addr_d  = bus.wr_addr;
                    data_d  = bus.wr_data;
                    state_d = S_WRITE;
                end else if (bus.scan_en) begin
                    state_d = S_SETTLE;
                end
            end
            S_WRITE: begin
                mem_addr_d = addr_q;
                state_d    = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                mem_addr_d = addr_q;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
                state_d    = S_VERIFY;
`else
                state_d    = S_IDLE;
`endif
            end
            S_VERIFY: begin
                mem_addr_d = addr_q;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
                wr_err_d   = (bus.mem_rdata != data_q);
`endif
                state_d    = S_IDLE;
            end
            S_SETTLE: begin
                mem_addr_d = scan_ptr_q;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                mem_addr_d   = scan_ptr_q;
                disp_byte_d  = bus.mem_rdata;
                disp_addr_d  = scan_ptr_q;
                disp_valid_d = 1'b1;
                tmr_load     = 1'b1;
                state_d      = S_DWELL;
            end
            S_DWELL: begin
                // A write preempts the dwell without advancing scan_ptr, so
                // the same byte is recaptured with its new value afterwards.
                if (bus.wr_req) begin
                    addr_d  = bus.wr_addr;
                    data_d  = bus.wr_data;
                    state_d = S_WRITE;
                end else if (!bus.scan_en) begin
                    disp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (tmr_done) begin
                    scan_ptr_d = scan_ptr_q + ADDR_W'(1);
                    state_d    = S_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            scan_ptr_q   <= '0;
            mem_addr_q   <= '0;
            disp_byte_q  <= '0;
            disp_addr_q  <= '0;
            disp_valid_q <= 1'b0;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
            wr_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            scan_ptr_q   <= scan_ptr_d;
            mem_addr_q   <= mem_addr_d;
            disp_byte_q  <= disp_byte_d;
            disp_addr_q  <= disp_addr_d;
            disp_valid_q <= disp_valid_d;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
            wr_err_q     <= wr_err_d;
`endif
        end
    end

    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_data   = data_q;
    assign bus.mem_store  = (state_q == S_WRITE);
    assign bus.wr_ack     = (state_q == S_WR_HOLD);
    assign bus.disp_byte  = disp_byte_q;
    assign bus.disp_addr  = disp_addr_q;
    assign bus.disp_valid = disp_valid_q;
`ifdef MEMORY_ACCESS_CTRL_VERIFY_EN
    assign bus.wr_err     = wr_err_q;
`else
    assign bus.wr_err     = 1'b0;
`endif

endmodule
